gf163_inverter: RTL and testbench

- Sequential multiplicative inverter for GF(2^163), irreducible polynomial x^163+x^80+x^47+x^9+1.
- It is the division-side counterpart of the combinational karatsuba163 multiplier, and instantiates one karatsuba163 instance.
- Uses Itoh-Tsujii: a^-1 = a^(2^163-2), built from one field square per cycle or one field multiply per cycle.
- Sits beside the multiplier in the ECC datapath; used for projective-to-affine conversion and field division.

---
 rtl/gf163_pkg.sv | 49 ++++
 rtl/gf163_sqr.sv | 20 ++
 rtl/karatsuba163.sv | 42 ++++
 rtl/gf163_inverter.sv | 105 ++++++++++
 tb/tb_gf163_inverter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/gf163_pkg.sv
// Shared GF(2^163) constants, Itoh-Tsujii step table, FSM states and reduction helper.
// Field polynomial: x^163 + x^80 + x^47 + x^9 + 1.
package gf163_pkg;

  localparam int GF_M    = 163;
  localparam int TAP_A   = 80;
  localparam int TAP_B   = 47;
  localparam int TAP_C   = 9;
  localparam int LATENCY = 172;
  localparam int CNT_W   = 7;
  localparam int STEP_W  = 4;
  localparam int LAST_STEP = 8;

  typedef logic [GF_M-1:0] gf_t;

  typedef enum logic [2:0] {
    IDLE,
    SQR,
    MUL,
    FIN,
    DONE
  } state_t;

  // Squarings per step and whether that step's multiplier operand is b1 (1) or the
  // value produced by the previous step (0). Chain: 1,2,4,5,10,20,40,80,81,162.
  localparam logic [CNT_W-1:0] J_TBL [0:8] = '{
    7'd1, 7'd2, 7'd1, 7'd5, 7'd10, 7'd20, 7'd40, 7'd1, 7'd81
  };
  localparam logic Y_SEL [0:8] = '{
    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0
  };

  // Folds a degree-324 polynomial back below degree 163. Walking from the top down
  // lets bits folded into the upper half be folded again on a later iteration.
  function automatic gf_t gf_reduce(input logic [2*GF_M-2:0] v);
    logic [2*GF_M-2:0] t;
    t = v;
    for (int i = 2*GF_M-2; i >= GF_M; i--) begin
      if (t[i]) begin
        t[i-GF_M]       = ~t[i-GF_M];
        t[i-GF_M+TAP_C] = ~t[i-GF_M+TAP_C];
        t[i-GF_M+TAP_B] = ~t[i-GF_M+TAP_B];
        t[i-GF_M+TAP_A] = ~t[i-GF_M+TAP_A];
      end
    end
    return t[GF_M-1:0];
  endfunction

endpackage

// File: rtl/gf163_sqr.sv
// Combinational GF(2^163) squarer: interleave zeros, then reduce. XOR-only.
module gf163_sqr
  import gf163_pkg::*;
(
  input  logic [GF_M-1:0] a,
  output logic [GF_M-1:0] p
);

  logic [2*GF_M-2:0] spread;

  always_comb begin
    spread = '0;
    for (int i = 0; i < GF_M; i++) begin
      spread[2*i] = a[i];
    end
  end

  assign p = gf_reduce(spread);

endmodule

// File: rtl/karatsuba163.sv
// Combinational GF(2^163) multiplier: one-level Karatsuba split at bit 82, then reduce.
module karatsuba163
  import gf163_pkg::*;
(
  input  logic [GF_M-1:0] a,
  input  logic [GF_M-1:0] b,
  output logic [GF_M-1:0] p
);

  localparam int H = 82;

  function automatic logic [2*H-2:0] clmul(input logic [H-1:0] x, input logic [H-1:0] y);
    logic [2*H-2:0] acc;
    acc = '0;
    for (int i = 0; i < H; i++) begin
      if (y[i]) acc = acc ^ ({{(H-1){1'b0}}, x} << i);
    end
    return acc;
  endfunction

  logic [H-1:0]      a_lo, a_hi, b_lo, b_hi;
  logic [2*H-2:0]    p_lo, p_hi, p_sum, p_mid;
  logic [2*GF_M-2:0] full;

  // Upper halves are 81 bits; the spare top bit is zero.
  assign a_lo = a[H-1:0];
  assign b_lo = b[H-1:0];
  assign a_hi = {1'b0, a[GF_M-1:H]};
  assign b_hi = {1'b0, b[GF_M-1:H]};

  assign p_lo  = clmul(a_lo, b_lo);
  assign p_hi  = clmul(a_hi, b_hi);
  assign p_sum = clmul(a_lo ^ a_hi, b_lo ^ b_hi);
  assign p_mid = p_sum ^ p_lo ^ p_hi;

  assign full = {162'b0, p_lo}
              ^ ({162'b0, p_mid} << H)
              ^ ({162'b0, p_hi} << (2*H));

  assign p = gf_reduce(full);

endmodule

// File: rtl/gf163_inverter.sv
// Itoh-Tsujii GF(2^163) inverter: 161 squarings + 9 multiplies + final square; done at T+172.
module gf163_inverter
  import gf163_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [GF_M-1:0] a,
  output logic            ready,
  output logic            done,
  output logic [GF_M-1:0] result,
  output logic            zero_in
);

  state_t state, state_nxt;

  gf_t               x, y, b1;
  gf_t               sq, prod;
  logic [STEP_W-1:0] step, step_inc;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              last_step;

  gf163_sqr u_sqr (
    .a (x),
    .p (sq)
  );

  karatsuba163 u_mul (
    .a (x),
    .b (y),
    .p (prod)
  );

  assign step_inc  = step + 4'd1;
  assign last_step = (step == STEP_W'(LAST_STEP));

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: begin
        ready     = 1'b1;
        done      = (state == DONE);
        accept    = start;
        state_nxt = start ? SQR : IDLE;
      end
      SQR:     if (cnt == 7'd1) state_nxt = MUL;
      MUL:     state_nxt = last_step ? FIN : SQR;
      FIN:     state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x       <= '0;
      y       <= '0;
      b1      <= '0;
      step    <= '0;
      cnt     <= '0;
      result  <= '0;
      zero_in <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            x    <= a;
            y    <= a;
            b1   <= a;
            step <= '0;
            cnt  <= J_TBL[0];
          end
        end
        SQR: begin
          x   <= sq;
          cnt <= cnt - 7'd1;
        end
        MUL: begin
          x <= prod;
          if (!last_step) begin
            // Load the operand the next step multiplies by.
            y    <= Y_SEL[step_inc] ? b1 : prod;
            step <= step_inc;
            cnt  <= J_TBL[step_inc];
          end
        end
        FIN: begin
          x       <= sq;
          result  <= sq;
          zero_in <= (b1 == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf163_inverter.sv
// Directed + back-to-back random bench for gf163_inverter with a queue-based scoreboard.
module tb_gf163_inverter;

  localparam int M = 163;
  localparam int NRAND = 120;
  localparam int LAT_AFTER_ISSUE = 171;

  typedef struct {
    logic [M-1:0] res;
    logic         zero;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [M-1:0] a;
  logic         ready;
  logic         done;
  logic [M-1:0] result;
  logic         zero_in;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  exp_t sb[$];

  logic [M-1:0] p_low;

  gf163_inverter dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .ready   (ready),
    .done    (done),
    .result  (result),
    .zero_in (zero_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Shift-and-add reference multiply, independent of the DUT's Karatsuba structure.
  function automatic logic [M-1:0] m_mul(input logic [M-1:0] x, input logic [M-1:0] y);
    logic [M-1:0] r, s;
    r = '0;
    s = x;
    for (int i = 0; i < M; i++) begin
      if (y[i]) r = r ^ s;
      if (s[M-1]) s = (s << 1) ^ p_low;
      else        s = s << 1;
    end
    return r;
  endfunction

  // a^(2^163-2) = prod_{k=1..162} a^(2^k)
  function automatic logic [M-1:0] m_inv(input logic [M-1:0] x);
    logic [M-1:0] r, s;
    r = {{(M-1){1'b0}}, 1'b1};
    s = x;
    for (int k = 1; k < M; k++) begin
      s = m_mul(s, s);
      r = m_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [M-1:0] rand_nz();
    logic [191:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    if (w[M-1:0] == '0) w[0] = 1'b1;
    return w[M-1:0];
  endfunction

  // Scoreboard side: pop and compare on every done pulse.
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 163'(done_cnt), 163'(0));
      end else begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("zero_in", {162'b0, zero_in}, {162'b0, e.zero});
      end
    end
  end

  // Called at a negedge with ready=1; returns at the negedge of cycle T+1.
  task automatic issue(input logic [M-1:0] v, input logic [M-1:0] er, input logic ez);
    exp_t e;
    e.res  = er;
    e.zero = ez;
    sb.push_back(e);
    a     = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 163'(n), 163'(LAT_AFTER_ISSUE));
  endtask

  initial begin
    logic [M-1:0] one, xinv, va, vb;
    int lat, busy_bad, dc0;

    p_low = '0;
    p_low[0] = 1'b1; p_low[9] = 1'b1; p_low[47] = 1'b1; p_low[80] = 1'b1;
    one = '0; one[0] = 1'b1;
    xinv = '0; xinv[162] = 1'b1; xinv[79] = 1'b1; xinv[46] = 1'b1; xinv[8] = 1'b1;

    rst = 1'b1; start = 1'b0; a = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {162'b0, ready}, 163'(1));
    chk("rst_done", {162'b0, done}, 163'(0));
    chk("rst_result", result, '0);
    chk("rst_zero", {162'b0, zero_in}, 163'(0));
    rst = 1'b0;
    @(negedge clk);

    // a=1: exact latency and busy window
    issue(one, one, 1'b0);
    busy_bad = 0;
    for (int k = 1; k <= LAT_AFTER_ISSUE; k++) begin
      if (ready || done) busy_bad++;
      @(negedge clk);
    end
    chk("busy_window", 163'(busy_bad), 163'(0));
    chk("done_t172", {162'b0, done}, 163'(1));
    chk("ready_t172", {162'b0, ready}, 163'(1));
    @(negedge clk);
    chk("done_pulse", {162'b0, done}, 163'(0));

    // a=x
    issue(163'(2), xinv, 1'b0);
    wait_done(lat);
    chk("lat_x", 163'(lat), 163'(LAT_AFTER_ISSUE));
    chk("x_times_inv", m_mul(163'(2), result), one);
    @(negedge clk);

    // a=0
    issue('0, '0, 1'b1);
    wait_done(lat);
    chk("lat_zero", 163'(lat), 163'(LAT_AFTER_ISSUE));
    @(negedge clk);

    // back-to-back random operands, new start in every done cycle
    dc0 = done_cnt;
    va = rand_nz();
    issue(va, m_inv(va), 1'b0);
    for (int i = 0; i < NRAND; i++) begin
      wait_done(lat);
      if (i < 3) chk("lat_b2b", 163'(lat), 163'(LAT_AFTER_ISSUE));
      if (i < NRAND - 1) begin
        va = rand_nz();
        issue(va, m_inv(va), 1'b0);
      end
    end
    @(negedge clk);
    chk("b2b_done_count", 163'(done_cnt - dc0), 163'(NRAND));

    // starts during busy window are ignored
    dc0 = done_cnt;
    va = rand_nz();
    vb = rand_nz();
    issue(va, m_inv(va), 1'b0);
    repeat (9) @(negedge clk);
    a = vb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (89) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = '0;
    wait_done(lat);
    chk("lat_ignore", 163'(lat), 163'(LAT_AFTER_ISSUE - 100));
    repeat (200) @(negedge clk);
    chk("ignore_one_done", 163'(done_cnt - dc0), 163'(1));

    // reset mid-operation
    dc0 = done_cnt;
    va = rand_nz();
    issue(va, m_inv(va), 1'b0);
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk("abort_ready", {162'b0, ready}, 163'(1));
    chk("abort_result", result, '0);
    chk("abort_zero", {162'b0, zero_in}, 163'(0));
    repeat (200) @(negedge clk);
    chk("abort_no_done", 163'(done_cnt - dc0), 163'(0));
    va = rand_nz();
    issue(va, m_inv(va), 1'b0);
    wait_done(lat);
    chk("lat_after_abort", 163'(lat), 163'(LAT_AFTER_ISSUE));
    @(negedge clk);

    chk("sb_empty", 163'(sb.size()), 163'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
